// File: rtl/dec_pkg.sv
// dec_pkg: shared state encoding and block geometry for the turbo decoder input FSM.
package dec_pkg;
    localparam int CNT_W    = 13;
    localparam int K_SMALL  = 1056;
    localparam int K_LARGE  = 6144;
    localparam int TAIL_LEN = 4;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_TAIL   = 3'd2,
        S_START  = 3'd3,
        S_DECODE = 3'd4,
        S_DONE   = 3'd5
    } state_t;
endpackage

// File: rtl/dec_blk_counter.sv
// dec_blk_counter: block/tail position counter; wraps to zero on the terminal count.
module dec_blk_counter import dec_pkg::*; (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign term_o = en_i && (cnt_q == limit_i - 1'b1);
    assign cnt_o  = cnt_q;
    always_comb cnt_d = (clr_i || term_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= cnt_d;
endmodule

// File: rtl/dec_fsm.sv
// dec_fsm: turbo decoder input control FSM (load, tail, launch, wait, done).
module dec_fsm import dec_pkg::*; #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             blk_start,
  input  logic             blk_size,
  input  logic             in_valid,
  input  logic             dec_done,
  output logic             ready,
  output logic             clear_output,
  output logic             buf_wen,
  output logic [CNT_W-1:0] buf_addr,
  output logic             tail_wen,
  output logic [1:0]       tail_idx,
  output logic             dec_start,
  output logic             out_valid,
  output logic             err_overrun,
`ifdef DEC_TIMEOUT_EN
  output logic             dec_timeout,
`endif
  output logic [2:0]       state
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d, cnt, limit;
  logic             err_q, err_d, accept, cnt_en, term, wd_hit;
  assign accept = state_q == S_IDLE && blk_start;
  assign cnt_en = in_valid && (state_q == S_LOAD || state_q == S_TAIL);
  assign limit  = state_q == S_TAIL ? CNT_W'(TAIL_LEN) : k_q;
  dec_blk_counter u_cnt (
    .clk    (clock),
    .clr_i  (aclr || accept),
    .en_i   (cnt_en),
    .limit_i(limit),
    .cnt_o  (cnt),
    .term_o (term)
  );
`ifdef DEC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;
  logic            to_q;
  assign wd_hit      = state_q == S_DECODE && !dec_done && wd_q == WD_W'(TIMEOUT_CYC - 1);
  assign dec_timeout = to_q;
  always_ff @(posedge clock) begin
    wd_q <= (aclr || state_q != S_DECODE) ? '0 : wd_q + 1'b1;
    to_q <= (aclr || accept) ? 1'b0 : to_q | wd_hit;
  end
`else
  assign wd_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    err_d   = accept ? 1'b0 : err_q | (blk_start && state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        state_d = blk_start ? S_LOAD : S_IDLE;
        k_d     = blk_start ? (blk_size ? CNT_W'(K_LARGE) : CNT_W'(K_SMALL)) : k_q;
      end
      S_LOAD:   state_d = term ? S_TAIL : S_LOAD;
      S_TAIL:   state_d = term ? S_START : S_TAIL;
      S_START:  state_d = S_DECODE;
      S_DECODE: state_d = (dec_done || wd_hit) ? S_DONE : S_DECODE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q <= S_IDLE;
      k_q     <= CNT_W'(K_SMALL);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end
  assign buf_wen      = state_q == S_LOAD && in_valid;
  assign tail_wen     = state_q == S_TAIL && in_valid;
  assign buf_addr     = cnt;
  assign tail_idx     = cnt[1:0];
  assign ready        = state_q == S_IDLE;
  assign clear_output = state_q == S_IDLE;
  assign dec_start    = state_q == S_START;
  assign out_valid    = state_q == S_DONE;
  assign err_overrun  = err_q;
  assign state        = state_q;
endmodule
